// File: rtl/morse_serializador.sv
// Morse serializer: latches a pattern, sends it LSB first, one bit per TICK_DIV cycles, then a low gap.
// Optional looping mode is enabled by defining MORSE_REPEAT_EN (adds the repetir input).
module morse_serializador #(
    parameter int WIDTH     = 22,
    parameter int TICK_DIV  = 4,
    parameter int GAP_UNITS = 3,
    parameter int LW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] patron,
    input  logic [LW-1:0]    longitud,
    input  logic             cargar,
`ifdef MORSE_REPEAT_EN
    input  logic             repetir,
`endif
    output logic             listo,
    input  logic             abortar,
    output logic             salida,
    output logic             ocupado,
    output logic             fin
);

    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int UW = (GAP_UNITS > 1) ? $clog2(GAP_UNITS) : 1;
    localparam logic [DW-1:0]    DIV_LAST  = DW'(TICK_DIV - 1);
    localparam logic [UW-1:0]    UNIT_LAST = UW'(GAP_UNITS - 1);
    localparam logic [LW-1:0]    LEN_MAX   = LW'(WIDTH);
    localparam logic [WIDTH-1:0] ONE_HOT0  = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d, sel_d;
    logic [LW-1:0]    len_q, len_d, len_in;
    logic [LW-1:0]    idx_q, idx_d;
    logic [DW-1:0]    div_q, div_d;
    logic [UW-1:0]    unit_q, unit_d;
    logic             salida_d, listo_d, ocupado_d, fin_d;
`ifdef MORSE_REPEAT_EN
    logic             rep_q, rep_d;
`endif

    // Handshake: a load transfers on a rising edge where cargar=1 and listo=1;
    // cargar while listo=0 is dropped, never queued.
    assign len_in = (longitud > LEN_MAX) ? LEN_MAX : longitud;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        idx_d   = idx_q;
        div_d   = div_q;
        unit_d  = unit_q;
        fin_d   = 1'b0;
`ifdef MORSE_REPEAT_EN
        rep_d   = rep_q;
`endif
        case (state_q)
            IDLE: begin
                if (cargar) begin
                    pat_d   = patron;
                    len_d   = len_in;
                    idx_d   = '0;
                    div_d   = '0;
                    unit_d  = '0;
`ifdef MORSE_REPEAT_EN
                    rep_d   = repetir;
`endif
                    state_d = (len_in == '0) ? GAP : SEND;
                end
            end
            SEND: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (idx_q == len_q - LW'(1)) begin
                        idx_d   = '0;
                        unit_d  = '0;
                        state_d = GAP;
                    end else begin
                        idx_d = idx_q + LW'(1);
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            GAP: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (unit_q == UNIT_LAST) begin
                        unit_d  = '0;
                        idx_d   = '0;
                        fin_d   = 1'b1;
                        state_d = IDLE;
`ifdef MORSE_REPEAT_EN
                        // Looping restarts the pattern from bit 0 without releasing listo.
                        if (rep_q) state_d = (len_q == '0) ? GAP : SEND;
`endif
                    end else begin
                        unit_d = unit_q + UW'(1);
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (abortar && (state_q != IDLE)) begin
            state_d = IDLE;
            idx_d   = '0;
            div_d   = '0;
            unit_d  = '0;
            fin_d   = 1'b0;
        end

        // Outputs are registered, so they are derived from the next state and index.
        sel_d     = ONE_HOT0 << idx_d;
        salida_d  = (state_d == SEND) && (|(pat_d & sel_d));
        listo_d   = (state_d == IDLE);
        ocupado_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            div_q   <= '0;
            unit_q  <= '0;
            salida  <= 1'b0;
            listo   <= 1'b1;
            ocupado <= 1'b0;
            fin     <= 1'b0;
`ifdef MORSE_REPEAT_EN
            rep_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            div_q   <= div_d;
            unit_q  <= unit_d;
            salida  <= salida_d;
            listo   <= listo_d;
            ocupado <= ocupado_d;
            fin     <= fin_d;
`ifdef MORSE_REPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

endmodule

// File: tb/tb_morse_serializador.sv
// Bench for morse_serializador: expected output sequences are built from the transmission rules
// (bits held TD cycles, then a fixed low gap, then a fin pulse) and compared cycle by cycle.
module tb_morse_serializador;

    localparam int WIDTH = 22;
    localparam int TD    = 4;
    localparam int GAPU  = 3;
    localparam int LW    = $clog2(WIDTH + 1);

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] patron;
    logic [LW-1:0]    longitud;
    logic             cargar;
    logic             abortar;
    logic             listo;
    logic             salida;
    logic             ocupado;
    logic             fin;
`ifdef MORSE_REPEAT_EN
    logic             repetir;
`endif

    int total;
    int bad;

    // Expected {listo, ocupado, fin, salida} per cycle.
    logic [3:0] exp_q[$];

    morse_serializador #(
        .WIDTH(WIDTH),
        .TICK_DIV(TD),
        .GAP_UNITS(GAPU)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .patron(patron),
        .longitud(longitud),
        .cargar(cargar),
`ifdef MORSE_REPEAT_EN
        .repetir(repetir),
`endif
        .listo(listo),
        .abortar(abortar),
        .salida(salida),
        .ocupado(ocupado),
        .fin(fin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] p, input logic [LW-1:0] l);
        patron   = p;
        longitud = l;
        cargar   = 1'b1;
        next_cycle();
        cargar   = 1'b0;
    endtask

    task automatic model_push(input logic [WIDTH-1:0] p, input int l, input bit with_idle);
        int n;
        n = (l > WIDTH) ? WIDTH : l;
        for (int b = 0; b < n; b++)
            for (int t = 0; t < TD; t++)
                exp_q.push_back({3'b010, p[b]});
        for (int t = 0; t < GAPU * TD; t++)
            exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1010);
        if (with_idle) exp_q.push_back(4'b1000);
    endtask

    task automatic test_reset();
        logic [3:0] o;
        rst_n = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        o = {listo, ocupado, fin, salida};
        total++;
        if (o !== 4'b1000) begin
            bad++;
            $display("FAIL reset_async got=%b want=1000", o);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            o = {listo, ocupado, fin, salida};
            total++;
            if (o !== 4'b1000) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got=%b want=1000", k, o);
            end
            next_cycle();
        end
    endtask

    task automatic test_normal();
        logic [3:0] e, o;
        int k;
        exp_q.delete();
        model_push(22'h00000B, 4, 1'b1);
        do_load(22'h00000B, 5'd4);
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = {listo, ocupado, fin, salida};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL normal cyc=%0d got=%b want=%b", k, o, e);
            end
            k++;
            if (exp_q.size() > 0) next_cycle();
        end
    endtask

    task automatic test_busy_ignored();
        logic [3:0] e, o;
        int k;
        exp_q.delete();
        model_push(22'h00000B, 4, 1'b1);
        do_load(22'h00000B, 5'd4);
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = {listo, ocupado, fin, salida};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL busy_load cyc=%0d got=%b want=%b", k, o, e);
            end
            if (k == 5) begin
                patron   = 22'h3FFFFF;
                longitud = 5'd22;
                cargar   = 1'b1;
            end
            if (k == 6) cargar = 1'b0;
            k++;
            if (exp_q.size() > 0) next_cycle();
        end
        cargar = 1'b0;
    endtask

    task automatic test_boundaries();
        logic [3:0] e, o;
        int k;
        logic [LW-1:0] lens [2];
        lens[0] = 5'd25;
        lens[1] = 5'd0;
        for (int r = 0; r < 2; r++) begin
            exp_q.delete();
            model_push(22'h3FFFFF, int'(lens[r]), 1'b1);
            do_load(22'h3FFFFF, lens[r]);
            k = 0;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                o = {listo, ocupado, fin, salida};
                total++;
                if (o !== e) begin
                    bad++;
                    $display("FAIL boundary len=%0d cyc=%0d got=%b want=%b", lens[r], k, o, e);
                end
                k++;
                if (exp_q.size() > 0) next_cycle();
            end
        end
    endtask

    task automatic test_abort();
        logic [3:0] e, o;
        exp_q.delete();
        model_push(22'h00000B, 4, 1'b1);
        do_load(22'h00000B, 5'd4);
        for (int k = 0; k <= 9; k++) begin
            e = exp_q.pop_front();
            o = {listo, ocupado, fin, salida};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL abort_pre cyc=%0d got=%b want=%b", k, o, e);
            end
            if (k < 9) next_cycle();
        end
        exp_q.delete();
        abortar = 1'b1;
        next_cycle();
        abortar = 1'b0;
        for (int k = 0; k < 2; k++) begin
            o = {listo, ocupado, fin, salida};
            total++;
            if (o !== 4'b1000) begin
                bad++;
                $display("FAIL abort_idle cyc=%0d got=%b want=1000", k, o);
            end
            next_cycle();
        end
        // abortar while idle must not block an accept in the same cycle
        patron   = 22'h000001;
        longitud = 5'd2;
        cargar   = 1'b1;
        abortar  = 1'b1;
        next_cycle();
        cargar   = 1'b0;
        abortar  = 1'b0;
        o = {listo, ocupado, fin, salida};
        total++;
        if (o !== 4'b0101) begin
            bad++;
            $display("FAIL abort_in_idle_load got=%b want=0101", o);
        end
        abortar = 1'b1;
        next_cycle();
        abortar = 1'b0;
        o = {listo, ocupado, fin, salida};
        total++;
        if (o !== 4'b1000) begin
            bad++;
            $display("FAIL abort_second got=%b want=1000", o);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_gap();
        logic [3:0] e, o;
        exp_q.delete();
        model_push(22'h00000B, 4, 1'b1);
        do_load(22'h00000B, 5'd4);
        for (int k = 0; k <= 20; k++) begin
            e = exp_q.pop_front();
            o = {listo, ocupado, fin, salida};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL rstgap_pre cyc=%0d got=%b want=%b", k, o, e);
            end
            if (k < 20) next_cycle();
        end
        exp_q.delete();
        #3;
        rst_n = 1'b0;
        #1;
        o = {listo, ocupado, fin, salida};
        total++;
        if (o !== 4'b1000) begin
            bad++;
            $display("FAIL rstgap_async got=%b want=1000", o);
        end
        next_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            o = {listo, ocupado, fin, salida};
            total++;
            if (o !== 4'b1000) begin
                bad++;
                $display("FAIL rstgap_after cyc=%0d got=%b want=1000", k, o);
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] e, o;
        int k;
        int fin_idx;
        exp_q.delete();
        model_push(22'h000002, 2, 1'b0);
        fin_idx = exp_q.size() - 1;
        model_push(22'h000005, 3, 1'b1);
        do_load(22'h000002, 5'd2);
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = {listo, ocupado, fin, salida};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL back_to_back cyc=%0d got=%b want=%b", k, o, e);
            end
            if (k == fin_idx) begin
                patron   = 22'h000005;
                longitud = 5'd3;
                cargar   = 1'b1;
            end
            if (k == fin_idx + 1) cargar = 1'b0;
            k++;
            if (exp_q.size() > 0) next_cycle();
        end
        cargar = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] e, o;
        logic [WIDTH-1:0] p;
        int l;
        int k;
        for (int r = 0; r < 16; r++) begin
            p = WIDTH'($urandom);
            l = $urandom_range(0, 25);
            exp_q.delete();
            model_push(p, l, 1'b1);
            do_load(p, LW'(l));
            k = 0;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                o = {listo, ocupado, fin, salida};
                total++;
                if (o !== e) begin
                    bad++;
                    $display("FAIL random r=%0d p=%h len=%0d cyc=%0d got=%b want=%b", r, p, l, k, o, e);
                end
                k++;
                if (exp_q.size() > 0) next_cycle();
            end
        end
    endtask

`ifdef MORSE_REPEAT_EN
    task automatic test_repeat();
        logic [3:0] e, o;
        int k;
        exp_q.delete();
        for (int lp = 0; lp < 3; lp++)
            for (int c = 0; c < 16; c++)
                exp_q.push_back({1'b0, 1'b1, (lp > 0 && c == 0), (c < TD)});
        repetir = 1'b1;
        do_load(22'h000001, 5'd1);
        repetir = 1'b0;
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = {listo, ocupado, fin, salida};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL repeat cyc=%0d got=%b want=%b", k, o, e);
            end
            k++;
            if (exp_q.size() > 0) next_cycle();
        end
        abortar = 1'b1;
        next_cycle();
        abortar = 1'b0;
        for (int c = 0; c < 2; c++) begin
            o = {listo, ocupado, fin, salida};
            total++;
            if (o !== 4'b1000) begin
                bad++;
                $display("FAIL repeat_abort cyc=%0d got=%b want=1000", c, o);
            end
            next_cycle();
        end
    endtask
`endif

    initial begin
        total    = 0;
        bad      = 0;
        patron   = '0;
        longitud = '0;
        cargar   = 1'b0;
        abortar  = 1'b0;
`ifdef MORSE_REPEAT_EN
        repetir  = 1'b0;
`endif
        test_reset();
        test_normal();
        test_busy_ignored();
        test_boundaries();
        test_abort();
        test_reset_mid_gap();
        test_back_to_back();
        test_random();
`ifdef MORSE_REPEAT_EN
        test_repeat();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
